// File: rtl/tc_pkg.sv
// Shared constants for the memory-mapped down-counting timer: FSM states,
// register offsets, CTRL bit layout, mode codes and the bridge base addresses.
package tc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  // Word offsets, decoded from Addr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TC1_BASE = 32'h0000_7F10;

endpackage

// File: rtl/timer_counter.sv
// 32-bit down-counting timer with CTRL/PRESET/COUNT registers, one-shot or
// auto-reload modes and a maskable level interrupt.
module timer_counter
  import tc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] Din,
  input  logic        WE,
  output logic [31:0] Dout,
  output logic        IRQ
);

  tc_state_e        state, state_nxt;
  logic [3:0]       ctrl, ctrl_nxt;
  logic [CNT_W-1:0] preset, preset_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             irq_flag, irq_nxt;

  // Only Addr[3:2] selects a register; the bridge has already decoded the rest.
  logic unused_addr;
  assign unused_addr = ^{Addr[31:4], Addr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      ctrl     <= ctrl_nxt;
      preset   <= preset_nxt;
      count    <= count_nxt;
      irq_flag <= irq_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ctrl_nxt   = ctrl;
    preset_nxt = preset;
    count_nxt  = count;
    irq_nxt    = irq_flag;

    case (state)
      ST_IDLE: if (ctrl[CTRL_EN]) state_nxt = ST_LOAD;
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl[CTRL_EN]) begin
          state_nxt = ST_IDLE;
        end else if (count > CNT_W'(1)) begin
          count_nxt = count - CNT_W'(1);
        end else begin
          count_nxt = '0;
          irq_nxt   = 1'b1;
          state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        state_nxt = ST_IDLE;
        if (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD) irq_nxt = 1'b0;
        else                                                  ctrl_nxt[CTRL_EN] = 1'b0;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Software writes come last so they override any FSM update in the same cycle.
    if (WE) begin
      case (Addr[3:2])
        REG_CTRL: begin
          ctrl_nxt = Din[3:0];
          irq_nxt  = 1'b0;
        end
        REG_PRESET: begin
          preset_nxt = Din[CNT_W-1:0];
          irq_nxt    = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (Addr[3:2])
      REG_CTRL:   Dout = {28'd0, ctrl};
      REG_PRESET: Dout = 32'(preset);
      REG_COUNT:  Dout = 32'(count);
      default:    Dout = 32'd0;
    endcase
  end

  assign IRQ = irq_flag & ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus random register
// traffic, compared against a cycle-level behavioural timer model.
module tb_timer_counter;
  import tc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] Din = '0;
  logic        WE = 1'b0;
  logic [31:0] Dout;
  logic        IRQ;

  int n_chk = 0;
  int n_fail = 0;

  timer_counter #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .Din(Din), .WE(WE), .Dout(Dout), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: age counts edges since the timer left idle
  // (1 = reload edge, >=2 = counting), -1 marks the cycle after expiry.
  logic [3:0]  m_ctrl;
  logic [31:0] m_pre, m_cnt;
  bit          m_irq;
  int          m_age;

  task automatic m_reset();
    m_ctrl = '0; m_pre = '0; m_cnt = '0; m_irq = 0; m_age = 0;
  endtask

  task automatic m_step(input bit we, input logic [31:0] a, input logic [31:0] d);
    logic [3:0]  n_ctrl = m_ctrl;
    logic [31:0] n_pre  = m_pre;
    logic [31:0] n_cnt  = m_cnt;
    bit          n_irq  = m_irq;
    int          n_age  = m_age;
    if (m_age == 0) begin
      if (m_ctrl[0]) n_age = 1;
    end else if (m_age == 1) begin
      n_cnt = m_pre; n_age = 2;
    end else if (m_age == -1) begin
      n_age = 0;
      if (m_ctrl[2:1] == 2'd1) n_irq = 0;
      else n_ctrl[0] = 1'b0;
    end else if (!m_ctrl[0]) begin
      n_age = 0;
    end else if (m_cnt > 1) begin
      n_cnt = m_cnt - 1; n_age = m_age + 1;
    end else begin
      n_cnt = 0; n_irq = 1; n_age = -1;
    end
    if (we && a[3:2] == 2'd0) begin n_ctrl = d[3:0]; n_irq = 0; end
    if (we && a[3:2] == 2'd1) begin n_pre = d;       n_irq = 0; end
    m_ctrl = n_ctrl; m_pre = n_pre; m_cnt = n_cnt; m_irq = n_irq; m_age = n_age;
  endtask

  function automatic logic [31:0] m_rd(input int off);
    case (off)
      0:       return {28'd0, m_ctrl};
      1:       return m_pre;
      2:       return m_cnt;
      default: return 32'd0;
    endcase
  endfunction

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    Addr = a; #1; d = Dout;
  endtask

  task automatic check_all(input logic [31:0] base);
    logic [31:0] d;
    for (int off = 0; off < 4; off++) begin
      rd(base + 32'(off * 4), d);
      chk($sformatf("rd_off%0d", off), d, m_rd(off));
    end
    chk("irq", {31'd0, IRQ}, {31'd0, m_irq & m_ctrl[3]});
  endtask

  task automatic tick(input bit we, input logic [31:0] a, input logic [31:0] d);
    Addr = a; Din = d; WE = we;
    @(posedge clk);
    if (!reset) m_reset();
    else m_step(we, a, d);
    #1;
    WE = 1'b0;
    check_all(a[4] ? TC1_BASE : TC0_BASE);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, TC0_BASE, 32'd0);
  endtask

  logic [31:0] rv;
  int pulses;

  initial begin
    m_reset();
    // Reset held low: writes must not land.
    #2;
    check_all(TC0_BASE);
    tick(1'b1, TC0_BASE,     32'hF);
    tick(1'b1, TC0_BASE + 4, 32'h1234);
    tick(1'b1, TC0_BASE + 8, 32'h55);
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    reset = 1'b1;
    idle(2);
    rd(TC0_BASE + 4, rv); chk("rst_pre", rv, 32'd0);

    // One-shot, P=5
    tick(1'b1, TC0_BASE + 4, 32'd5);
    tick(1'b1, TC0_BASE, 32'h9);
    idle(2); rd(TC0_BASE + 8, rv); chk("m0_cnt_e2", rv, 32'd5);
    idle(4); rd(TC0_BASE + 8, rv); chk("m0_cnt_e6", rv, 32'd1);
    idle(1); chk("m0_irq_e7", {31'd0, IRQ}, 32'd1);
    idle(3); chk("m0_irq_hold", {31'd0, IRQ}, 32'd1);
    rd(TC0_BASE, rv); chk("m0_ctrl", rv, 32'h8);
    tick(1'b1, TC0_BASE, 32'h8); chk("m0_irq_clr", {31'd0, IRQ}, 32'd0);

    // Auto-reload, P=3: period 6
    tick(1'b1, TC0_BASE + 4, 32'd3);
    tick(1'b1, TC0_BASE, 32'hB);
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      idle(1);
      if (IRQ) pulses++;
    end
    chk("m1_pulses", 32'(pulses), 32'd4);
    tick(1'b1, TC0_BASE, 32'h0);
    idle(3);

    // Masked expiry
    tick(1'b1, TC0_BASE + 4, 32'd2);
    tick(1'b1, TC0_BASE, 32'h1);
    idle(4);
    chk("mask_irq", {31'd0, IRQ}, 32'd0);
    rd(TC0_BASE + 8, rv); chk("mask_cnt", rv, 32'd0);
    tick(1'b1, TC0_BASE, 32'h8); chk("mask_irq_after", {31'd0, IRQ}, 32'd0);

    // Disable mid-count, COUNT write and reserved read
    tick(1'b1, TC0_BASE + 4, 32'd100);
    tick(1'b1, TC0_BASE, 32'h1);
    idle(12); rd(TC0_BASE + 8, rv); chk("dis_cnt90", rv, 32'd90);
    tick(1'b1, TC0_BASE, 32'h0);
    idle(3); rd(TC0_BASE + 8, rv); chk("dis_frozen", rv, 32'd89);
    tick(1'b1, TC0_BASE + 8, 32'hFFFF);
    rd(TC0_BASE + 8, rv); chk("cnt_ro", rv, 32'd89);
    rd(TC0_BASE + 12, rv); chk("rsvd", rv, 32'd0);

    // P=0 expires at E3; async reset drops IRQ without a clock edge
    tick(1'b1, TC0_BASE + 4, 32'd0);
    tick(1'b1, TC0_BASE, 32'h9);
    idle(3); chk("p0_irq_e3", {31'd0, IRQ}, 32'd1);
    reset = 1'b0; #1;
    chk("async_irq", {31'd0, IRQ}, 32'd0);
    m_reset();
    check_all(TC0_BASE);
    reset = 1'b1;
    idle(1);

    // Random register traffic on TC1
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0; #1;
        m_reset();
        check_all(TC1_BASE);
        reset = 1'b1;
      end else if ($urandom_range(0, 3) == 0) begin
        int off = $urandom_range(0, 3);
        logic [31:0] d;
        d = (off == 0) ? 32'($urandom_range(0, 15)) :
            (off == 1) ? 32'($urandom_range(0, 6)) : $urandom;
        tick(1'b1, TC1_BASE + 32'(off * 4), d);
      end else begin
        tick(1'b0, TC1_BASE + 32'($urandom_range(0, 3) * 4), $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped 32-bit down-counting timer; the device behind each of the bridge's TC0/TC1 ports.
- Two instances are used: TC0 at 0x7F00–0x7F0B and TC1 at 0x7F10–0x7F1B.
- The bridge supplies the full address, write data and write enable; this block returns read data and drives one interrupt line toward the CP0 HWInt inputs.
- Three word registers: CTRL, PRESET, COUNT.

Parameters:
- CNT_W, 32, width of PRESET and COUNT. The 32-bit bus is the only supported value.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; all registers clear while low.
- Addr  in  32  byte address from the bridge; only Addr[3:2] is decoded.
- Din  in  32  write data.
- WE  in  1  write strobe, already qualified by the bridge address decode.
- Dout  out  32  combinational read data.
- IRQ  out  1  interrupt request, level, active-high.

Behaviour:
- Register map (Addr[3:2]):
  - 0 = CTRL: bit0 En, bits[2:1] Mode, bit3 IM; bits[31:4] read as 0.
  - 1 = PRESET: read/write.
  - 2 = COUNT: read-only; writes are ignored.
  - 3 = reserved: reads 0, writes ignored.
- Reset (async, reset==0): ctrl=0, preset=0, count=0, irq_flag=0, state=IDLE. Hence Dout follows the decode with all registers 0, and IRQ=0.
- Reads: Dout is combinational from Addr[3:2] with zero latency and no side effects.
- Writes take effect at the posedge where WE=1:
  - CTRL stores Din[3:0].
  - PRESET stores Din.
  - Any write to CTRL or PRESET clears irq_flag.
- IRQ = irq_flag & ctrl.IM (combinational).
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if ctrl.En, go to LOAD.
  - LOAD: count <= preset; go to CNT.
  - CNT:
    - if !ctrl.En, go to IDLE and hold count;
    - else if count > 1, count <= count-1;
    - else count <= 0, irq_flag <= 1, go to INT.
  - INT: go to IDLE.
    - Mode 0 (one-shot): also clear ctrl.En; irq_flag is held until software writes CTRL or PRESET.
    - Mode 1 (auto-reload): irq_flag is cleared, giving a 1-cycle pulse; with En still set, the next period starts automatically.
  - Modes 2 and 3 behave as mode 0.
- Latency: for a CTRL write with En=1 at edge E0 and PRESET=P (P≥1):
  - LOAD at E1; CNT with count=P at E2;
  - count=1 at E(P+1);
  - INT with irq_flag=1 at E(P+2).
  - Mode-1 period is P+3 cycles.
- Boundary conditions:
  - P=0 or P=1: INT is reached at E3; count reads 0 then.
  - A PRESET write during CNT does not change the running count; it is used at the next LOAD.
  - Clearing En during LOAD: LOAD still completes, then CNT exits to IDLE on the following cycle.
  - A CTRL write in the same cycle as the INT-state En clear: the software write wins, and ctrl takes Din[3:0].
  - A CTRL/PRESET write in the same cycle the FSM sets irq_flag: the write wins, and irq_flag=0.
  - reset low mid-count forces IDLE and zeros immediately, with no IRQ.
  - No wrap-around: count never decrements below 0.

Decomposition:
- Shared package tc_pkg holds:
  - state encoding (IDLE=2'd0, LOAD=2'd1, CNT=2'd2, INT=2'd3);
  - register offsets (CTRL=2'd0, PRESET=2'd1, COUNT=2'd2);
  - CTRL bit indices (EN=0, MODE=2:1, IM=3);
  - mode codes (ONESHOT=2'd0, RELOAD=2'd1);
  - the TC0/TC1 base addresses, so the bridge decode shares the same constants.
- No sub-module: the register file, FSM and down-counter stay in one module.

Test Plan:
- Reset: hold reset=0 with WE pulses applied → Dout=0 for Addr 0x7F00/04/08/0C, IRQ=0. Release reset → registers stay 0.
- Mode 0: PRESET=5, then CTRL=0x9 (En, IM, mode 0) at E0 → COUNT reads 5 at E2 and 1 at E6; IRQ=1 at E7 and stays 1; CTRL reads 0x8. Writing CTRL=0x8 drops IRQ on the next edge.
- Mode 1: PRESET=3, CTRL=0xB → IRQ is a 1-cycle pulse every 6 cycles; 4 pulses seen over 24 cycles; COUNT reloads to 3 each period.
- Mask: PRESET=2, CTRL=0x1 (IM=0) → FSM reaches INT, IRQ stays 0, COUNT=0. Then CTRL=0x8 → IRQ remains 0, because the write cleared irq_flag.
- Disable and reserved: PRESET=100, CTRL=0x1, at COUNT=90 write CTRL=0 → COUNT freezes at the value reached. A write to COUNT (0x7F08 ← 0xFFFF) is ignored. A read of 0x7F0C returns 0.
- Edge values: PRESET=0, CTRL=0x9 → IRQ at E3. An async reset asserted at that point clears IRQ immediately, without waiting for a clock edge.
